// File: rtl/ram_port_arbiter.sv
// Round-robin two-port front end for a shared RAM_64bit with registered reads.
// Sequences IDLE -> ACCESS -> (READ_OUT) -> DONE and owns the shared data bus drive.
module ram_port_arbiter #(
    parameter int ADDR_WIDTH = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  a_req,
    input  logic                  a_write,
    input  logic [ADDR_WIDTH-1:0] a_address,
    input  logic [1:0]            a_size,
    input  logic [63:0]           a_wdata,
    output logic [63:0]           a_rdata,
    output logic                  a_ack,
    input  logic                  b_req,
    input  logic                  b_write,
    input  logic [ADDR_WIDTH-1:0] b_address,
    input  logic [1:0]            b_size,
    input  logic [63:0]           b_wdata,
    output logic [63:0]           b_rdata,
    output logic                  b_ack,
    output logic [ADDR_WIDTH-1:0] mem_address,
    inout  logic [63:0]           mem_data,
    output logic                  mem_chip_select,
    output logic                  mem_write_enable,
    output logic                  mem_output_enable,
    output logic [1:0]            mem_size,
    output logic                  busy,
    output logic                  grant
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_READ_OUT,
        S_DONE
    } state_t;

    state_t                  r_state;
    state_t                  w_next_state;
    logic                    r_last_grant;
    logic                    r_grant;
    logic                    r_write;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [1:0]              r_size;
    logic [63:0]             r_wdata;
    logic [63:0]             r_a_rdata;
    logic [63:0]             r_b_rdata;
    logic                    r_a_ack;
    logic                    r_b_ack;
    logic                    w_any_req;
    logic                    w_pick_b;
    logic                    w_drive;

    // On a tie the port that did not win last time gets the grant.
    assign w_any_req = a_req | b_req;
    assign w_pick_b  = b_req & (~a_req | ~r_last_grant);

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:     if (w_any_req) w_next_state = S_ACCESS;
            S_ACCESS:   w_next_state = r_write ? S_DONE : S_READ_OUT;
            S_READ_OUT: w_next_state = S_DONE;
            S_DONE:     w_next_state = S_IDLE;
            default:    w_next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_last_grant <= 1'b1;
            r_grant      <= 1'b0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_size       <= '0;
            r_wdata      <= '0;
            r_a_rdata    <= '0;
            r_b_rdata    <= '0;
            r_a_ack      <= 1'b0;
            r_b_ack      <= 1'b0;
        end else begin
            r_state <= w_next_state;
            r_a_ack <= (w_next_state == S_DONE) && !r_grant;
            r_b_ack <= (w_next_state == S_DONE) && r_grant;
            if (r_state == S_IDLE && w_any_req) begin
                r_grant      <= w_pick_b;
                r_last_grant <= w_pick_b;
                r_write      <= w_pick_b ? b_write   : a_write;
                r_addr       <= w_pick_b ? b_address : a_address;
                r_size       <= w_pick_b ? b_size    : a_size;
                r_wdata      <= w_pick_b ? b_wdata   : a_wdata;
            end
            if (r_state == S_READ_OUT) begin
                if (r_grant) r_b_rdata <= mem_data;
                else         r_a_rdata <= mem_data;
            end
        end
    end

    // Bus controls are gated by reset so an interrupted write never reaches the RAM.
    always_comb begin
        mem_chip_select   = !reset && (r_state == S_ACCESS || r_state == S_READ_OUT);
        mem_write_enable  = !reset && (r_state == S_ACCESS) && r_write;
        mem_output_enable = !reset && (r_state == S_READ_OUT);
        mem_address       = reset ? '0 : r_addr;
        mem_size          = reset ? '0 : r_size;
    end

    assign w_drive  = !reset && (r_state == S_ACCESS) && r_write;
    assign mem_data = w_drive ? r_wdata : 'z;

    assign a_rdata = r_a_rdata;
    assign b_rdata = r_b_rdata;
    assign a_ack   = r_a_ack;
    assign b_ack   = r_b_ack;
    assign busy    = (r_state != S_IDLE);
    assign grant   = r_grant;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter with a little-endian byte RAM model
// (registered read, address wrap) standing in for RAM_64bit.
module tb_ram_port_arbiter;

    logic        clock = 1'b0;
    logic        reset;
    logic        a_req, a_write, b_req, b_write;
    logic [7:0]  a_address, b_address;
    logic [1:0]  a_size, b_size;
    logic [63:0] a_wdata, b_wdata;
    logic [63:0] a_rdata, b_rdata;
    logic        a_ack, b_ack;
    logic [7:0]  mem_address;
    tri   [63:0] mem_data;
    logic        mem_chip_select, mem_write_enable, mem_output_enable;
    logic [1:0]  mem_size;
    logic        busy, grant;

    int n_pass  = 0;
    int n_total = 0;

    logic [7:0]  ram [256];
    logic [63:0] ram_q;
    logic        ram_init;

    always #5 clock = ~clock;

    ram_port_arbiter #(.ADDR_WIDTH(8)) dut (
        .clock(clock), .reset(reset),
        .a_req(a_req), .a_write(a_write), .a_address(a_address), .a_size(a_size),
        .a_wdata(a_wdata), .a_rdata(a_rdata), .a_ack(a_ack),
        .b_req(b_req), .b_write(b_write), .b_address(b_address), .b_size(b_size),
        .b_wdata(b_wdata), .b_rdata(b_rdata), .b_ack(b_ack),
        .mem_address(mem_address), .mem_data(mem_data),
        .mem_chip_select(mem_chip_select), .mem_write_enable(mem_write_enable),
        .mem_output_enable(mem_output_enable), .mem_size(mem_size),
        .busy(busy), .grant(grant)
    );

    function automatic logic [63:0] ram_read(input logic [7:0] a, input logic [1:0] s);
        logic [63:0] r = '0;
        for (int i = 0; i < 8; i++)
            if (i < (1 << s)) r[8*i +: 8] = ram[8'(int'(a) + i)];
        return r;
    endfunction

    always @(posedge clock) begin
        if (ram_init) begin
            for (int i = 0; i < 256; i++) ram[i] <= 8'(i) ^ 8'h5A;
        end else if (mem_chip_select) begin
            if (mem_write_enable) begin
                for (int i = 0; i < 8; i++)
                    if (i < (1 << mem_size)) ram[8'(int'(mem_address) + i)] <= mem_data[8*i +: 8];
            end else begin
                ram_q <= ram_read(mem_address, mem_size);
            end
        end
    end

    assign mem_data = (mem_chip_select && mem_output_enable) ? ram_q : 'z;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues one request from an idle controller and reports cycles-to-ack and returned rdata.
    task automatic run_op(input bit port, input bit wr, input logic [7:0] addr, input logic [1:0] sz,
                          input logic [63:0] wd, output int lat, output logic [63:0] rd);
        int guard = 0;
        while (busy && guard < 10) begin tick(); guard++; end
        if (port) begin b_req = 1; b_write = wr; b_address = addr; b_size = sz; b_wdata = wd; end
        else      begin a_req = 1; a_write = wr; a_address = addr; a_size = sz; a_wdata = wd; end
        lat = 99;
        rd  = '0;
        for (int c = 1; c <= 8; c++) begin
            tick();
            if (c == 1) begin
                if (port) begin b_address = ~addr; b_size = ~sz; b_wdata = ~wd; end
                else      begin a_address = ~addr; a_size = ~sz; a_wdata = ~wd; end
            end
            if (port ? b_ack : a_ack) begin
                lat = c;
                rd  = port ? b_rdata : a_rdata;
                break;
            end
        end
        a_req = 0;
        b_req = 0;
    endtask

    task automatic test_reset();
        reset = 1; ram_init = 1;
        a_req = 1; b_req = 1; a_write = 0; b_write = 0;
        a_address = 8'h00; b_address = 8'h00; a_size = 2'b00; b_size = 2'b00;
        a_wdata = '0; b_wdata = '0;
        tick();
        ram_init = 0;
        tick();
        n_total++; if (a_ack !== 1'b0 || b_ack !== 1'b0) $display("FAIL reset_ack got a=%0b b=%0b exp 0", a_ack, b_ack); else n_pass++;
        n_total++; if (a_rdata !== 64'h0 || b_rdata !== 64'h0) $display("FAIL reset_rdata got a=%h b=%h exp 0", a_rdata, b_rdata); else n_pass++;
        n_total++; if (grant !== 1'b0 || busy !== 1'b0) $display("FAIL reset_grant_busy got %0b%0b exp 00", grant, busy); else n_pass++;
        n_total++; if ({mem_chip_select, mem_write_enable, mem_output_enable} !== 3'b000) $display("FAIL reset_mem_ctl got %b exp 000", {mem_chip_select, mem_write_enable, mem_output_enable}); else n_pass++;
        n_total++; if (mem_address !== 8'h00 || mem_size !== 2'b00) $display("FAIL reset_mem_addr got %h/%b exp 00/00", mem_address, mem_size); else n_pass++;
        reset = 0;
        tick();
        n_total++; if (grant !== 1'b0 || busy !== 1'b1) $display("FAIL first_grant got grant=%0b busy=%0b exp 0/1", grant, busy); else n_pass++;
        n_total++; if (mem_chip_select !== 1'b1 || mem_output_enable !== 1'b0) $display("FAIL access_ctl got cs=%0b oe=%0b exp 1/0", mem_chip_select, mem_output_enable); else n_pass++;
        a_req = 0; b_req = 0;
        tick();
        n_total++; if (mem_output_enable !== 1'b1 || mem_write_enable !== 1'b0) $display("FAIL readout_ctl got oe=%0b we=%0b exp 1/0", mem_output_enable, mem_write_enable); else n_pass++;
        tick();
        n_total++; if (a_ack !== 1'b1 || b_ack !== 1'b0) $display("FAIL first_ack got a=%0b b=%0b exp 1/0", a_ack, b_ack); else n_pass++;
        n_total++; if (a_rdata !== 64'h5A) $display("FAIL first_rdata got %h exp 5a", a_rdata); else n_pass++;
        tick();
        n_total++; if (busy !== 1'b0 || a_ack !== 1'b0) $display("FAIL back_idle got busy=%0b ack=%0b exp 0/0", busy, a_ack); else n_pass++;
    endtask

    task automatic test_write_then_read();
        int lat;
        logic [63:0] rd;
        run_op(1'b1, 1'b1, 8'h04, 2'b11, 64'h1122334455667788, lat, rd);
        n_total++; if (lat !== 2) $display("FAIL b_write_latency got %0d exp 2", lat); else n_pass++;
        n_total++; if (b_rdata !== 64'h0) $display("FAIL write_keeps_rdata got %h exp 0", b_rdata); else n_pass++;
        n_total++; if (grant !== 1'b1) $display("FAIL b_grant got %0b exp 1", grant); else n_pass++;
        run_op(1'b0, 1'b0, 8'h08, 2'b00, 64'h0, lat, rd);
        n_total++; if (lat !== 3) $display("FAIL a_read_latency got %0d exp 3", lat); else n_pass++;
        n_total++; if (rd !== 64'h44) $display("FAIL a_read_byte got %h exp 44", rd); else n_pass++;
        n_total++; if (b_rdata !== 64'h0) $display("FAIL b_rdata_untouched got %h exp 0", b_rdata); else n_pass++;
    endtask

    task automatic test_halfword();
        int lat;
        logic [63:0] rd;
        run_op(1'b0, 1'b1, 8'h0E, 2'b01, 64'hBEEF, lat, rd);
        n_total++; if (lat !== 2) $display("FAIL a_write_latency got %0d exp 2", lat); else n_pass++;
        run_op(1'b1, 1'b0, 8'h0E, 2'b01, 64'h0, lat, rd);
        n_total++; if (rd !== 64'h000000000000BEEF) $display("FAIL b_read_half got %h exp beef", rd); else n_pass++;
        n_total++; if (a_rdata !== 64'h44) $display("FAIL a_rdata_held got %h exp 44", a_rdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [3:0] exp_g = 4'b1010;
        int acks = 0;
        int last_cyc = 0;
        bit prev_ack = 0;
        int guard = 0;
        while (busy && guard < 10) begin tick(); guard++; end
        a_write = 0; a_address = 8'h04; a_size = 2'b11;
        b_write = 0; b_address = 8'h0E; b_size = 2'b01;
        a_req = 1; b_req = 1;
        for (int cyc = 1; cyc <= 30 && acks < 4; cyc++) begin
            tick();
            n_total++; if (a_ack && b_ack) $display("FAIL ack_overlap cycle %0d got both exp one", cyc); else n_pass++;
            if (a_ack || b_ack) begin
                n_total++; if (grant !== exp_g[acks]) $display("FAIL rr_grant[%0d] got %0b exp %0b", acks, grant, exp_g[acks]); else n_pass++;
                if (a_ack) begin
                    n_total++; if (a_rdata !== 64'h1122334455667788) $display("FAIL rr_a_rdata got %h exp 1122334455667788", a_rdata); else n_pass++;
                end else begin
                    n_total++; if (b_rdata !== 64'hBEEF) $display("FAIL rr_b_rdata got %h exp beef", b_rdata); else n_pass++;
                end
                if (acks > 0) begin
                    n_total++; if (cyc - last_cyc !== 4) $display("FAIL rr_period got %0d exp 4", cyc - last_cyc); else n_pass++;
                end
                last_cyc = cyc;
                acks++;
                if (acks == 4) begin a_req = 0; b_req = 0; end
                prev_ack = 1;
            end else begin
                n_total++; if (busy !== !prev_ack) $display("FAIL rr_busy cycle %0d got %0b exp %0b", cyc, busy, !prev_ack); else n_pass++;
                prev_ack = 0;
            end
        end
        a_req = 0; b_req = 0;
        n_total++; if (acks !== 4) $display("FAIL rr_ack_count got %0d exp 4", acks); else n_pass++;
    endtask

    task automatic test_wrap();
        int lat;
        logic [63:0] rd;
        run_op(1'b0, 1'b1, 8'hFF, 2'b11, 64'h0102030405060708, lat, rd);
        n_total++; if (lat !== 2) $display("FAIL wrap_write_latency got %0d exp 2", lat); else n_pass++;
        run_op(1'b1, 1'b0, 8'h00, 2'b00, 64'h0, lat, rd);
        n_total++; if (rd !== 64'h07) $display("FAIL wrap_byte0 got %h exp 07", rd); else n_pass++;
        run_op(1'b0, 1'b0, 8'hFF, 2'b11, 64'h0, lat, rd);
        n_total++; if (rd !== 64'h0102030405060708) $display("FAIL wrap_word got %h exp 0102030405060708", rd); else n_pass++;
    endtask

    task automatic test_reset_midop();
        int lat;
        logic [63:0] rd;
        int guard = 0;
        while (busy && guard < 10) begin tick(); guard++; end
        a_write = 1; a_address = 8'h10; a_size = 2'b00; a_wdata = 64'hAA; a_req = 1;
        tick();
        a_req = 0;
        reset = 1;
        #1;
        n_total++; if (mem_chip_select !== 1'b0 || mem_write_enable !== 1'b0) $display("FAIL midwrite_gate got cs=%0b we=%0b exp 0/0", mem_chip_select, mem_write_enable); else n_pass++;
        tick();
        n_total++; if (a_ack !== 1'b0 || busy !== 1'b0) $display("FAIL midwrite_ack got ack=%0b busy=%0b exp 0/0", a_ack, busy); else n_pass++;
        reset = 0;
        tick();
        n_total++; if (a_ack !== 1'b0) $display("FAIL midwrite_late_ack got %0b exp 0", a_ack); else n_pass++;
        run_op(1'b1, 1'b0, 8'h10, 2'b00, 64'h0, lat, rd);
        n_total++; if (rd !== 64'h4A) $display("FAIL midwrite_prior got %h exp 4a", rd); else n_pass++;
        guard = 0;
        while (busy && guard < 10) begin tick(); guard++; end
        b_write = 0; b_address = 8'h04; b_size = 2'b11; b_req = 1;
        tick();
        tick();
        b_req = 0;
        reset = 1;
        tick();
        n_total++; if (b_ack !== 1'b0) $display("FAIL midread_ack got %0b exp 0", b_ack); else n_pass++;
        n_total++; if (b_rdata !== 64'h0 || a_rdata !== 64'h0) $display("FAIL midread_rdata got a=%h b=%h exp 0", a_rdata, b_rdata); else n_pass++;
        reset = 0;
        tick();
        n_total++; if (b_ack !== 1'b0 || busy !== 1'b0) $display("FAIL midread_after got ack=%0b busy=%0b exp 0/0", b_ack, busy); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_write_then_read();
        test_halfword();
        test_back_to_back();
        test_wrap();
        test_reset_midop();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
